uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports 5–9 data bits, none/even/odd parity, 1 or 2 stop bits, a 2-FF input synchroniser, per-byte parity and framing error tags, and a first-word-fall-through receive FIFO with a valid/ready output port. It sits between the board RX pin and the host-command/image-load logic, so the consumer can stall without losing bytes.

## Interface
- `CLK_FREQ`, 100_000_000, clock frequency in Hz
- `BAUD`, 115200, line rate in baud
- `CLKS_PER_BIT`, CLK_FREQ/BAUD, clocks per bit; must be ≥ 4
- `DATA_BITS`, 8, data bits per frame, 5..9, LSB first
- `PARITY`, 0, 0 = none, 1 = even, 2 = odd
- `STOP_BITS`, 1, 1 or 2
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  asynchronous, active-high reset
- `rx`  in  1  asynchronous serial line, idle high
- `m_valid`  out  1  FIFO non-empty; head entry presented
- `m_ready`  in  1  consumer accepts head when `m_valid`=1
- `m_data`  out  DATA_BITS  head data
- `m_parity_err`  out  1  head entry had a parity mismatch (always 0 when PARITY=0)
- `m_frame_err`  out  1  head entry had a stop bit sampled low
- `overrun`  out  1  sticky; a frame was dropped because the FIFO was full
- `clear_err`  in  1  clears `overrun`
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries held
- `busy`  out  1  FSM is not in IDLE

## Operation
- Synchroniser: two flops reset to 1. All logic uses the synchronised signal `rx_s`.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HI.
  - IDLE: counters cleared. `rx_s`=0 → START.
  - START: count to HALF = CLKS_PER_BIT/2 − 1. If `rx_s`=0 there → DATA with counter 0; if `rx_s`=1 → IDLE (glitch, nothing pushed).
  - DATA: sample at counter = CLKS_PER_BIT − 1, then clear the counter. Bit i goes to shift[i]. After bit DATA_BITS−1, go to PAR if PARITY≠0, else STOP.
  - PAR: sample one bit.
    - Even parity: error if XOR(data, par) = 1.
    - Odd parity: error if XOR(data, par) = 0.
  - STOP: sample STOP_BITS bits. Any low sample sets the frame error. At the last stop sample, push {frame_err, parity_err, data}. Then go to IDLE if `rx_s`=1, or to WAIT_HI if `rx_s`=0.
  - WAIT_HI: stay until `rx_s`=1, then → IDLE. This keeps a break condition from producing phantom frames.
- FIFO: circular buffer, FIFO_DEPTH entries × (DATA_BITS+2) bits.
  - Pop when `m_valid` && `m_ready`.
  - Push is accepted if count < FIFO_DEPTH, or if a pop happens in the same cycle.
  - On a refused push: drop the frame and set `overrun`=1.
  - Push and pop in the same cycle: count unchanged, pointers both advance.
  - Pointers wrap modulo FIFO_DEPTH.
- `overrun` is cleared by `clear_err`=1. If a refused push and `clear_err` occur in the same cycle, set wins.
- Outputs `m_data`/`m_*_err` are driven from the head entry. When empty they are 0.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - `m_valid`=0, `m_data`=0, `m_parity_err`=0, `m_frame_err`=0, `overrun`=0, `fifo_count`=0, `busy`=0
  - FSM in IDLE, FIFO emptied, synchroniser flops =1
- Reset asserted mid-frame aborts the frame. No partial push occurs.
- `rx` to `rx_s` latency is 2 clocks.
- Sample points after the START entry cycle:
  - start check at HALF+1 clocks
  - each later bit one CLKS_PER_BIT after the previous sample (bit centre ±1 clock)
- Push happens on the clock of the last stop-bit sample. `m_valid` and `fifo_count` update on the following edge.
- Total latency from the `rx` falling edge to `m_valid`=1: 2 + HALF + 1 + CLKS_PER_BIT×(DATA_BITS + (PARITY≠0) + STOP_BITS) + 1 clocks.
- The pop takes effect at the clock edge where `m_valid` && `m_ready`. The next entry (if any) is presented in the following cycle with no bubble.
- `busy` is 1 from the cycle after START is entered through the last WAIT_HI cycle.

## Test plan
Directed tests use CLKS_PER_BIT=16.

1. 8N1, send 0xA5 → one entry: `m_data`=0xA5, errors 0, `m_valid` high at the computed latency ±1, `fifo_count`=1. With `m_ready`=1 → count 0 on the next edge.
2. PARITY=1 (even), send 0x03:
   - parity bit 0 → `m_parity_err`=0
   - parity bit 1 → `m_parity_err`=1, `m_data`=0x03
   - Repeat with PARITY=2 and expect the inverse results.
3. Frame 0x55 with the stop bit low, then `rx` held low for 3 bit times, then idle, then 0x12 → exactly two entries: {0x55, `m_frame_err`=1} and {0x12, errors 0}.
4. `rx` low for 4 clocks (< HALF) → no push, `busy` returns to 0, `fifo_count` stays 0.
5. FIFO_DEPTH=4, `m_ready`=0, send 0x01..0x05 → `fifo_count`=4 and `overrun`=1. Draining returns 0x01..0x04 in order. `clear_err` clears `overrun`. A push with a simultaneous pop at full is accepted.
6. DATA_BITS=7, PARITY=2, STOP_BITS=2:
   - Assert `reset` mid-DATA → all outputs 0 immediately.
   - After release, send 0x5A → `m_data`=0x5A, errors 0.
   - Send a frame whose second stop bit is low → `m_frame_err`=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (5..9 data bits, none/even/odd parity, 1..2 stop bits) feeding a FWFT receive FIFO.
// Latency: rx fall to m_valid = 2 + HALF + 1 + CLKS_PER_BIT*(DATA_BITS+(PARITY!=0)+STOP_BITS) + 1 clocks.
// Backpressure: m_ready stalls the FIFO; a frame arriving while full (and not popping) is dropped and sets overrun.
module uart_rx_fifo #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [DATA_BITS-1:0]          m_data,
   output logic                          m_parity_err,
   output logic                          m_frame_err,
   output logic                          overrun,
   input  logic                          clear_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_BITS + 2;

   localparam logic [CW-1:0] HALF_C   = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST_C   = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic          LAST_STP = 1'(STOP_BITS - 1);
   localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

   state_t                state, state_nxt;
   logic                  rx_meta, rx_s;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic [BW-1:0]         bit_idx, bit_nxt;
   logic                  stop_idx, stop_nxt;
   logic [DATA_BITS-1:0]  shift, shift_nxt;
   logic                  par_err, perr_nxt;
   logic                  frm_err, ferr_nxt;
   logic                  push;
   logic [EW-1:0]         push_dat;

   logic [EW-1:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic                  pop, wr_rdy, wr_en;

   // Two-flop synchroniser; idles high so reset never looks like a start bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Receive FSM next-state, bit timing and frame assembly
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      stop_nxt  = stop_idx;
      shift_nxt = shift;
      perr_nxt  = par_err;
      ferr_nxt  = frm_err;
      push      = 1'b0;
      push_dat  = '0;
      case (state)
         IDLE: begin
            cnt_nxt  = '0;
            bit_nxt  = '0;
            stop_nxt = 1'b0;
            perr_nxt = 1'b0;
            ferr_nxt = 1'b0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            if (cnt == HALF_C) begin
               cnt_nxt   = '0;
               // a line that is high again at mid start bit was a glitch
               state_nxt = rx_s ? IDLE : DATA;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == LAST_C) begin
               cnt_nxt            = '0;
               shift_nxt[bit_idx] = rx_s;
               if (bit_idx == LAST_BIT) begin
                  bit_nxt   = '0;
                  state_nxt = (PARITY != 0) ? PAR : STOP;
               end else begin
                  bit_nxt = bit_idx + 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         PAR: begin
            if (cnt == LAST_C) begin
               cnt_nxt   = '0;
               perr_nxt  = (PARITY == 1) ? (^shift ^ rx_s) : ~(^shift ^ rx_s);
               state_nxt = STOP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == LAST_C) begin
               cnt_nxt  = '0;
               ferr_nxt = frm_err | ~rx_s;
               if (stop_idx == LAST_STP) begin
                  push      = 1'b1;
                  push_dat  = {frm_err | ~rx_s, par_err, shift};
                  // a line still low after the frame is a break: wait it out
                  state_nxt = rx_s ? IDLE : WAIT_HI;
               end else begin
                  stop_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WAIT_HI: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shift    <= '0;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bit_idx  <= bit_nxt;
         stop_idx <= stop_nxt;
         shift    <= shift_nxt;
         par_err  <= perr_nxt;
         frm_err  <= ferr_nxt;
      end
   end

   assign busy    = (state != IDLE);
   assign m_valid = (fifo_count != '0);
   assign pop     = m_valid & m_ready;
   // a full FIFO still takes a frame when the head leaves on the same edge
   assign wr_rdy  = (fifo_count < DEPTH_C) | pop;
   assign wr_en   = push & wr_rdy;

   assign {m_frame_err, m_parity_err, m_data} = m_valid ? mem[rd_ptr] : '0;

   // FIFO storage; entries past the read pointer are never presented, so no reset needed
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_dat;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Sticky overrun; a drop in the same cycle as clear_err keeps it set
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (push && !wr_rdy) begin
         overrun <= 1'b1;
      end else if (clear_err) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: 7 data bits, odd parity, 2 stop bits, 4-deep FIFO, 16 clocks per bit.
// Frames are built from a bit-level line model; expected entries are queued when a frame is sent.
// A negedge monitor drives m_ready and checks every handshaked entry against the queue.
module tb_uart_rx_fifo;
   localparam int CPB   = 16;
   localparam int DB    = 7;
   localparam int PAR   = 2;
   localparam int SB    = 2;
   localparam int DEPTH = 4;
   localparam int HALF  = CPB / 2 - 1;
   localparam int LAT   = 2 + HALF + 1 + CPB * (DB + 1 + SB) + 1;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic                     rx = 1'b1;
   logic                     m_ready = 1'b0;
   logic                     clear_err = 1'b0;
   logic                     m_valid, m_parity_err, m_frame_err, overrun, busy;
   logic [DB-1:0]            m_data;
   logic [$clog2(DEPTH):0]   fifo_count;

   int         n_checks = 0;
   int         n_pass = 0;
   int         rdy_mode = 0;     // 0 = hold off, 1 = random, 2 = always ready
   bit         exp_ovr = 1'b0;
   int         lat;
   logic [DB+1:0] exp_q[$];

   uart_rx_fifo #(
      .CLK_FREQ(100_000_000), .BAUD(115200), .CLKS_PER_BIT(CPB),
      .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .rx(rx),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
      .overrun(overrun), .clear_err(clear_err),
      .fifo_count(fifo_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Drive one frame onto the line; the expected entry is queued up front
   task automatic send_frame(input logic [DB-1:0] d, input bit flip_par, input bit [1:0] stop_low,
                             input int hold_low, input int gap, input bit exp_push);
      logic par;
      par = ~(^d) ^ flip_par;
      if (exp_push) exp_q.push_back({(stop_low != 2'b00), flip_par, d});
      @(posedge clk); #1 rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < DB; i++) begin
         #1 rx = d[i];
         repeat (CPB) @(posedge clk);
      end
      #1 rx = par;
      repeat (CPB) @(posedge clk);
      for (int s = 0; s < SB; s++) begin
         #1 rx = ~stop_low[s];
         repeat (CPB) @(posedge clk);
      end
      if (hold_low > 0) begin
         #1 rx = 1'b0;
         repeat (hold_low * CPB) @(posedge clk);
      end
      #1 rx = 1'b1;
      repeat (gap) @(posedge clk);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((fifo_count != 0 || exp_q.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_count", fifo_count, 0);
      chk("drain_pending", exp_q.size(), 0);
   endtask

   // Monitor: choose m_ready for the next edge and check any entry that will be taken
   always @(negedge clk) begin
      logic [DB+1:0] exp;
      case (rdy_mode)
         1:       m_ready = 1'($urandom_range(0, 1));
         2:       m_ready = 1'b1;
         default: m_ready = 1'b0;
      endcase
      if (m_valid === 1'b1 && m_ready) begin
         chk("entry_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            chk("entry", {m_frame_err, m_parity_err, m_data}, exp);
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      logic [DB-1:0] d;
      bit            fl;
      bit [1:0]      sl;
      int            hold;

      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_errs", {m_parity_err, m_frame_err}, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      repeat (3) @(posedge clk);

      // First frame: latency and head presentation with consumer stalled
      fork
         send_frame(7'h5A, 1'b0, 2'b00, 0, 8, 1'b1);
         begin
            @(posedge clk); #1;
            lat = 0;
            while (!m_valid && lat < 400) begin
               @(posedge clk); #1;
               lat++;
            end
         end
      join
      chk("latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
      chk("first_count", fifo_count, 1);
      chk("first_head", {m_frame_err, m_parity_err, m_data}, {2'b00, 7'h5A});
      rdy_mode = 2;
      @(negedge clk);
      @(posedge clk); #1;
      chk("count_after_pop", fifo_count, 0);
      rdy_mode = 1;

      // Parity good then bad, framing error with break, then a clean frame
      send_frame(7'h03, 1'b0, 2'b00, 0, 8, 1'b1);
      send_frame(7'h03, 1'b1, 2'b00, 0, 8, 1'b1);
      send_frame(7'h55, 1'b0, 2'b11, 3, 8, 1'b1);
      send_frame(7'h12, 1'b0, 2'b00, 0, 8, 1'b1);
      wait_drain(400);

      // Short low glitch: START entered, then abandoned
      @(posedge clk); #1 rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("glitch_busy_hi", busy, 1);
      rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("glitch_busy_lo", busy, 0);
      chk("glitch_count", fifo_count, 0);

      // Overflow with consumer stalled
      rdy_mode = 0;
      @(negedge clk);
      for (int i = 1; i <= 5; i++) begin
         bit p;
         p = (exp_q.size() < DEPTH);
         send_frame(DB'(i), 1'b0, 2'b00, 0, 8, p);
         if (!p) exp_ovr = 1'b1;
      end
      chk("full_count", fifo_count, DEPTH);
      chk("overrun_set", overrun, exp_ovr);
      clear_err = 1'b1;
      @(posedge clk); #1 clear_err = 1'b0;
      exp_ovr = 1'b0;
      chk("overrun_clr", overrun, exp_ovr);

      // Push at full with a pop on the same edge
      fork
         send_frame(7'h06, 1'b0, 2'b00, 0, 8, 1'b1);
         begin
            @(posedge clk);
            repeat (LAT - 1) @(posedge clk);
            #1 rdy_mode = 2;
            @(posedge clk);
            #1 rdy_mode = 0;
         end
      join
      chk("pushpop_count", fifo_count, DEPTH);
      chk("pushpop_overrun", overrun, exp_ovr);
      rdy_mode = 1;
      wait_drain(300);

      // Reset in the middle of the data bits
      rdy_mode = 0;
      @(negedge clk);
      send_frame(7'h2C, 1'b0, 2'b00, 0, 8, 1'b1);
      chk("pre_reset_valid", m_valid, 1);
      @(posedge clk); #1 rx = 1'b0;
      repeat (3 * CPB) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("midrst_valid", m_valid, 0);
      chk("midrst_data", {m_frame_err, m_parity_err, m_data}, 0);
      chk("midrst_count", fifo_count, 0);
      chk("midrst_busy", busy, 0);
      exp_q.delete();
      rx = 1'b1;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(posedge clk);
      rdy_mode = 1;
      send_frame(7'h5A, 1'b0, 2'b00, 0, 8, 1'b1);
      send_frame(7'h33, 1'b0, 2'b10, 0, 8, 1'b1);
      wait_drain(400);

      // Randomised traffic with random consumer stalls
      repeat (25) begin
         d    = DB'($urandom);
         fl   = ($urandom_range(0, 3) == 0);
         sl   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         hold = (sl[1] && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2)) : 0;
         send_frame(d, fl, sl, hold, int'($urandom_range(4, 20)), 1'b1);
      end
      wait_drain(500);
      chk("final_overrun", overrun, exp_ovr);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
